// File: rtl/dp_16x4_fifo_ctrl.sv
//------------------------------------------------------------------------------
// Module : dp_16x4_fifo_ctrl
// Single-clock FIFO controller for a 16x4 dual-port EBR RAM: pointers,
// occupancy, status flags and read-data valid.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dp_16x4_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AE_LEVEL   = 2,
  parameter int AF_LEVEL   = 14
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WrReq,
  input  logic                  RdReq,
  input  logic                  ClrErr,
  output logic                  WrEn,
  output logic [ADDR_WIDTH-1:0] addw,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  QValid,
  output logic                  Empty,
  output logic                  Full,
  output logic                  AlmostEmpty,
  output logic                  AlmostFull,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int                   CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]        DEPTH_C = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0]        AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0]        AF_C    = CW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, full_q, ae_q, af_q;
  logic                  qvalid_q;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_ok, rd_ok;

  // Acceptance looks only at the registered flags, so a same-cycle read
  // never frees room for a write and a same-cycle write never feeds a read.
  assign wr_ok = WrReq & ~full_q  & ~Reset;
  assign rd_ok = RdReq & ~empty_q & ~Reset;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (wr_ok) wptr_d = wptr_q + PTR_ONE;
    if (rd_ok) rptr_d = rptr_q + PTR_ONE;
    // A fresh error outranks a simultaneous clear.
    if (WrReq & full_q)       ovf_d = 1'b1;
    else if (ClrErr)          ovf_d = 1'b0;
    if (RdReq & empty_q)      unf_d = 1'b1;
    else if (ClrErr)          unf_d = 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      qvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == DEPTH_C);
      ae_q     <= (count_d <= AE_C);
      af_q     <= (count_d >= AF_C);
      qvalid_q <= rd_ok;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign WrEn        = wr_ok;
  assign RdEn        = rd_ok;
  assign addw        = wptr_q;
  assign addr        = rptr_q;
  assign QValid      = qvalid_q;
  assign Empty       = empty_q;
  assign Full        = full_q;
  assign AlmostEmpty = ae_q;
  assign AlmostFull  = af_q;
  assign Count       = count_q;
  assign Overflow    = ovf_q;
  assign Underflow   = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_dp_16x4_fifo_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_dp_16x4_fifo_ctrl
// Scoreboard bench for dp_16x4_fifo_ctrl with a behavioural 16x4 RAM.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dp_16x4_fifo_ctrl;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       WrReq = 1'b0;
  logic       RdReq = 1'b0;
  logic       ClrErr = 1'b0;
  logic       WrEn, RdEn, QValid, Empty, Full, AlmostEmpty, AlmostFull;
  logic       Overflow, Underflow;
  logic [3:0] addw, addr;
  logic [4:0] Count;
  logic [3:0] wdata = 4'h0;

  logic [3:0] ram [16];
  logic [3:0] ram_q;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [4:0] m_cnt;
  logic [3:0] m_w, m_r;
  logic       m_ovf, m_unf, m_qv;
  logic [3:0] sb [$];

  dp_16x4_fifo_ctrl #(.ADDR_WIDTH(4), .AE_LEVEL(2), .AF_LEVEL(14)) dut (
    .Clock(Clock), .Reset(Reset), .WrReq(WrReq), .RdReq(RdReq), .ClrErr(ClrErr),
    .WrEn(WrEn), .addw(addw), .RdEn(RdEn), .addr(addr), .QValid(QValid),
    .Empty(Empty), .Full(Full), .AlmostEmpty(AlmostEmpty), .AlmostFull(AlmostFull),
    .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clock = ~Clock;

  // Registered-data / registered-Q RAM as seen by the controller
  always @(posedge Clock) begin
    if (WrEn) ram[addw] <= wdata;
    if (RdEn) ram_q <= ram[addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic wr, input logic rd, input logic clr,
                      input logic rst, input logic [3:0] d);
    logic exp_we, exp_re;
    @(negedge Clock);
    WrReq = wr; RdReq = rd; ClrErr = clr; Reset = rst; wdata = d;
    #1;
    exp_we = wr && (m_cnt != 5'd16) && !rst;
    exp_re = rd && (m_cnt != 5'd0) && !rst;
    check("WrEn", WrEn, exp_we);
    check("RdEn", RdEn, exp_re);
    check("addw", addw, m_w);
    check("addr", addr, m_r);
    if (exp_we) sb.push_back(d);
    if (rst) begin
      m_cnt = 0; m_w = 0; m_r = 0; m_ovf = 0; m_unf = 0; m_qv = 0;
      sb.delete();
    end else begin
      if (wr && m_cnt == 5'd16) m_ovf = 1'b1;
      else if (clr)             m_ovf = 1'b0;
      if (rd && m_cnt == 5'd0)  m_unf = 1'b1;
      else if (clr)             m_unf = 1'b0;
      m_cnt = m_cnt + {4'd0, exp_we} - {4'd0, exp_re};
      if (exp_we) m_w = m_w + 4'd1;
      if (exp_re) m_r = m_r + 4'd1;
      m_qv = exp_re;
    end
    @(posedge Clock);
    #1;
    check("Count", Count, m_cnt);
    check("Empty", Empty, m_cnt == 0);
    check("Full", Full, m_cnt == 16);
    check("AlmostEmpty", AlmostEmpty, m_cnt <= 2);
    check("AlmostFull", AlmostFull, m_cnt >= 14);
    check("Overflow", Overflow, m_ovf);
    check("Underflow", Underflow, m_unf);
    check("QValid", QValid, m_qv);
    if (QValid) begin
      if (sb.size() == 0) check("Q_unexpected", 1, 0);
      else                check("Q", ram_q, sb.pop_front());
    end
  endtask

  task automatic push(input int n, input logic [3:0] base);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, base + 4'(i));
  endtask

  task automatic pop(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 4'h0);
  endtask

  initial begin
    m_cnt = 0; m_w = 0; m_r = 0; m_ovf = 0; m_unf = 0; m_qv = 0;
    step(0, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0);

    // Fill, overflow, sticky-vs-clear priority
    push(16, 4'h0);
    step(1, 0, 0, 0, 4'h5);
    step(1, 0, 1, 0, 4'h6);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);

    // Drain, underflow
    pop(16);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);

    // Pointer wrap
    push(10, 4'h3);
    pop(10);
    push(10, 4'h9);

    // Simultaneous at mid level, at empty, at full
    pop(5);
    step(1, 1, 0, 0, 4'hA);
    pop(5);
    step(1, 1, 0, 0, 4'hB);
    step(0, 0, 1, 0, 0);
    push(15, 4'h1);
    step(1, 1, 0, 0, 4'hC);
    step(0, 0, 1, 0, 0);
    pop(15);
    step(0, 0, 0, 0, 0);

    // Reset mid-operation
    step(0, 0, 0, 1, 0);
    push(8, 4'h4);
    pop(1);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 4'hE);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0),
           4'($urandom_range(0, 15)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
